// File: rtl/uart_pkg.sv
// Shared UART receive types: default bit period, byte FSM states and error bits.
// The optional parity stage (RX_PARITY_EN) reuses the same state encoding.
package uart_pkg;

  localparam int BAUD_DIV_DEF = 1157;

  localparam int ERR_FRAME = 0;
  localparam int ERR_OVR   = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

endpackage

// File: rtl/rx_word_if.sv
// Word handshake between the receiver and its consumer.
// master = receiver side, slave = consumer side.
interface rx_word_if;

  logic        iCall;
  logic        oDone;
  logic [15:0] oData;
  logic [1:0]  oErr;

  modport master (
    input  iCall,
    output oDone,
    output oData,
    output oErr
  );

  modport slave (
    output iCall,
    input  oDone,
    input  oData,
    input  oErr
  );

endinterface

// File: rtl/rx_byte_mod.sv
// Serial byte receiver: RXD synchronizer, bit timing and byte FSM.
// Even parity bit between data and stop when RX_PARITY_EN is defined.
module rx_byte_mod
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_o,
  output logic       good_o,
  output logic       err_o
);

  localparam logic [10:0] BAUD_M1 = 11'(BAUD_DIV - 1);
  localparam logic [10:0] HALF_M1 = 11'(BAUD_DIV / 2 - 1);

  rx_state_e   state_q, state_d;
  logic        s1_q, s1_d, s2_q, s2_d;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        brk_q, brk_d;
  logic        perr_q, perr_d;
  logic        good_q, good_d;
  logic        err_q, err_d;
  logic        rxs;
  logic        tick;

  assign rxs  = s2_q;
  assign tick = (cnt_q == BAUD_M1);

  always_comb begin
    s1_d    = rxd;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    brk_d   = brk_q;
    perr_d  = perr_q;
    good_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (brk_q) begin
          // after a break, wait for the line to go idle
          if (rxs) brk_d = 1'b0;
        end else if (!rxs) begin
          cnt_d   = '0;
          perr_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = '0;
          sh_d  = {rxs, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = ^{sh_q, rxs};
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rxs) begin
            err_d = 1'b1;
            brk_d = 1'b1;
          end else if (perr_q) begin
            err_d = 1'b1;
          end else begin
            good_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      brk_q   <= 1'b0;
      perr_q  <= 1'b0;
      good_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      brk_q   <= brk_d;
      perr_q  <= perr_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  assign data_o = sh_q;
  assign good_o = good_q;
  assign err_o  = err_q;

endmodule

// File: rtl/rx_word_mod.sv
// UART word receiver: pairs bytes (high first) into 16-bit words, buffers one.
// Build with RX_PARITY_EN for 8E1 frames; default is 8N1.
module rx_word_mod
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic      CLOCK,
  input  logic      RESET,
  input  logic      RXD,
  rx_word_if.master bus
);

  logic [7:0]  byte_w;
  logic        good_w;
  logic        err_w;

  logic        flag_q, flag_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] buf_q, buf_d;
  logic        vld_q, vld_d;
  logic        done_q, done_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  oerr_q, oerr_d;
  logic        wc;
  logic [15:0] word;

  rx_byte_mod #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk    (CLOCK),
    .rst    (RESET),
    .rxd    (RXD),
    .data_o (byte_w),
    .good_o (good_w),
    .err_o  (err_w)
  );

  assign wc   = good_w & flag_q;
  assign word = {hi_q, byte_w};

  always_comb begin
    flag_d = flag_q;
    hi_d   = hi_q;
    buf_d  = buf_q;
    vld_d  = vld_q;
    data_d = data_q;
    oerr_d = '0;
    oerr_d[ERR_FRAME] = err_w;
    if (err_w) flag_d = 1'b0;
    if (good_w) begin
      flag_d = ~flag_q;
      if (!flag_q) hi_d = byte_w;
    end
    // a fresh word may go straight out when the buffer is empty
    done_d = (vld_q | wc) & bus.iCall & ~done_q;
    if (done_d) data_d = vld_q ? buf_q : word;
    if (vld_q) begin
      if (done_d) begin
        vld_d = wc;
        if (wc) buf_d = word;
      end else if (wc) begin
        oerr_d[ERR_OVR] = 1'b1;
      end
    end else if (wc && !done_d) begin
      buf_d = word;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      flag_q <= 1'b0;
      hi_q   <= '0;
      buf_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      oerr_q <= '0;
    end else begin
      flag_q <= flag_d;
      hi_q   <= hi_d;
      buf_q  <= buf_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      data_q <= data_d;
      oerr_q <= oerr_d;
    end
  end

  assign bus.oDone = done_q;
  assign bus.oData = data_q;
  assign bus.oErr  = oerr_q;

endmodule

// File: tb/tb_rx_word_mod.sv
// Bench for rx_word_mod at BAUD_DIV=16: directed scenarios plus random frames.
module tb_rx_word_mod;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  rx_word_if bus ();

  rx_word_mod #(.BAUD_DIV(BD)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .RXD   (rxd),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] got[$];
  int          ndone = 0;
  int          e0 = 0;
  int          e1 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.oDone) begin
        got.push_back(bus.oData);
        ndone++;
      end
      if (bus.oErr[0]) e0++;
      if (bus.oErr[1]) e1++;
    end
  end

  task automatic clr();
    got.delete();
    ndone = 0;
    e0 = 0;
    e1 = 0;
  endtask

  task automatic hold(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd = v;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input bit par_ok, input int gap);
    hold(BD, 1'b0);
    for (int i = 0; i < 8; i++) hold(BD, b[i]);
`ifdef RX_PARITY_EN
    hold(BD, par_ok ? ^b : ~^b);
`endif
    hold(BD, stop_ok);
    if (gap > 0) hold(gap, 1'b1);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iCall = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oDone !== 1'b0) begin
      errors++;
      $display("FAIL rst_done: got %b expected 0", bus.oDone);
    end
    checks++;
    if (bus.oData !== 16'h0000) begin
      errors++;
      $display("FAIL rst_data: got %h expected 0000", bus.oData);
    end
    checks++;
    if (bus.oErr !== 2'b00) begin
      errors++;
      $display("FAIL rst_err: got %b expected 00", bus.oErr);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    clr();
    bus.iCall = 1'b1;
    send(8'hA0, 1, 1, 0);
    send(8'h05, 1, 1, 0);
    hold(3 * BD, 1'b1);
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 1", ndone);
    end
    checks++;
    if (got.size() == 0 || got[0] !== 16'hA005) begin
      errors++;
      $display("FAIL b2b_data: got %h expected a005",
               got.size() ? got[0] : 16'hxxxx);
    end
    checks++;
    if (e0 + e1 !== 0) begin
      errors++;
      $display("FAIL b2b_err: got %0d expected 0", e0 + e1);
    end
  endtask

  task automatic test_glitch();
    clr();
    hold(5, 1'b0);
    hold(4 * BD, 1'b1);
    checks++;
    if (ndone !== 0 || e0 !== 0 || e1 !== 0) begin
      errors++;
      $display("FAIL glitch: got done=%0d e0=%0d e1=%0d expected 0",
               ndone, e0, e1);
    end
  endtask

  task automatic test_stop_err();
    clr();
    bus.iCall = 1'b1;
    send(8'h12, 0, 1, 2 * BD);
    send(8'h34, 1, 1, 0);
    send(8'h56, 1, 1, 0);
    hold(3 * BD, 1'b1);
    chk("stop_e0", e0, 1);
    chk("stop_count", ndone, 1);
    chk("stop_data", got.size() ? int'(got[0]) : -1, 16'h3456);
    chk("stop_e1", e1, 0);
  endtask

  task automatic test_overrun();
    clr();
    bus.iCall = 1'b0;
    send(8'h11, 1, 1, 0);
    send(8'h22, 1, 1, 0);
    send(8'h33, 1, 1, 0);
    send(8'h44, 1, 1, 0);
    hold(3 * BD, 1'b1);
    chk("ovr_e1", e1, 1);
    chk("ovr_held", ndone, 0);
    bus.iCall = 1'b1;
    hold(10, 1'b1);
    chk("ovr_count", ndone, 1);
    chk("ovr_data", got.size() ? int'(got[0]) : -1, 16'h1122);
  endtask

  task automatic test_reset_mid();
    bit zero_ok;
    clr();
    bus.iCall = 1'b1;
    hold(BD, 1'b0);
    hold(3 * BD, 1'b1);
    hold(BD / 2, 1'b0);
    rst = 1'b1;
    zero_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rxd = 1'b1;
      if (bus.oDone !== 1'b0 || bus.oData !== 16'h0 ||
          bus.oErr !== 2'b0)
        zero_ok = 1'b0;
    end
    checks++;
    if (!zero_ok) begin
      errors++;
      $display("FAIL rstmid_zero: got nonzero expected all 0");
    end
    rst = 1'b0;
    hold(2 * BD, 1'b1);
    send(8'hBE, 1, 1, 0);
    send(8'hEF, 1, 1, 0);
    hold(3 * BD, 1'b1);
    chk("rstmid_count", ndone, 1);
    chk("rstmid_data", got.size() ? int'(got[0]) : -1, 16'hBEEF);
    chk("rstmid_err", e0 + e1, 0);
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    logic [7:0]  pend[$];
    logic [7:0]  b;
    bit          ok;
    clr();
    bus.iCall = 1'b1;
    for (int n = 0; n < 14; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send(b, ok, 1, ok ? int'($urandom_range(0, 3)) : 2 * BD);
      if (!ok) begin
        pend.delete();
      end else begin
        pend.push_back(b);
        if (pend.size() == 2) begin
          exp_q.push_back({pend[0], pend[1]});
          pend.delete();
        end
      end
    end
    hold(3 * BD, 1'b1);
    chk("rnd_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_word%0d", i),
          i < got.size() ? int'(got[i]) : -1, exp_q[i]);
    chk("rnd_ovr", e1, 0);
    // drain half-word so the next test starts aligned
    if (pend.size() != 0) send(8'h00, 0, 1, 2 * BD);
    hold(2 * BD, 1'b1);
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    clr();
    bus.iCall = 1'b1;
    send(8'h07, 1, 0, 0);
    hold(2 * BD, 1'b1);
    chk("par_bad_e0", e0, 1);
    chk("par_bad_done", ndone, 0);
    clr();
    send(8'h07, 1, 1, 0);
    send(8'h08, 1, 1, 0);
    hold(3 * BD, 1'b1);
    chk("par_good_count", ndone, 1);
    chk("par_good_data", got.size() ? int'(got[0]) : -1, 16'h0708);
  endtask
`endif

  initial begin
    bus.iCall = 1'b0;
    test_reset();
    test_back_to_back();
    test_glitch();
    test_stop_err();
    test_overrun();
    test_reset_mid();
    test_random();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
